// File: rtl/slave_direct_ctrl_gen.sv
// ============================================================================
// Module      : slave_direct_ctrl_gen
// Description : Slave-side direct line-state controller. Arbitrates for
//               the SC Tx port and, while direct control is enabled,
//               writes the forced line state to it. A write is repeated
//               only when the line state changes or when the optional
//               refresh period expires. When direct control ends, a
//               single release (idle) command is written and the port
//               is given back. One release write is always issued after
//               reset.
//
// Ports       : clk, rst                 - clock, async active-high reset
//               directControlEn          - direct-control enable level
//               directControlLineState   - line state to force (LS_W)
//               refreshPeriod            - re-write interval, 0 = off
//               SCTxPortGnt/Rdy          - arbiter grant / port ready
//               SCTxPortReq/WEn          - port request / write strobe
//               SCTxPortData/Cntl        - write data / write control
//               busy                     - controller not idle
//
// Options     : `define SLV_DRCT_IN_SYNC_EN to pass directControlEn and
//               directControlLineState through 2-flop synchronisers.
//               This adds 2 cycles to every input-to-WEn latency.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_direct_ctrl_gen #(
    parameter int                 DATA_W      = 8,
    parameter int                 CNTL_W      = 8,
    parameter int                 LS_W        = 2,
    parameter logic [CNTL_W-1:0]  DIRECT_CNTL = 8'h00,
    parameter logic [CNTL_W-1:0]  IDLE_CNTL   = 8'h05,
    parameter int                 REFRESH_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  directControlEn,
    input  logic [LS_W-1:0]       directControlLineState,
    input  logic [REFRESH_W-1:0]  refreshPeriod,
    input  logic                  SCTxPortGnt,
    input  logic                  SCTxPortRdy,
    output logic                  SCTxPortReq,
    output logic                  SCTxPortWEn,
    output logic [DATA_W-1:0]     SCTxPortData,
    output logic [CNTL_W-1:0]     SCTxPortCntl,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_REQ_REL  = 3'd1,
        S_WAIT_REL = 3'd2,
        S_REL_DONE = 3'd3,
        S_IDLE     = 3'd4,
        S_REQ_DIR  = 3'd5,
        S_WAIT_DIR = 3'd6,
        S_HOLD     = 3'd7
    } state_t;

    localparam logic [REFRESH_W-1:0] c_ref_one = {{(REFRESH_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic            w_en;
    logic [LS_W-1:0] w_ls;

`ifdef SLV_DRCT_IN_SYNC_EN
    logic [1:0]      r_en_sync;
    logic [LS_W-1:0] r_ls_sync0;
    logic [LS_W-1:0] r_ls_sync1;

    // The line-state bits are synchronised individually; a change that
    // straddles an edge may be seen for one cycle as a mixed value, which
    // at worst produces one extra direct write of the settled value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_sync  <= 2'b00;
            r_ls_sync0 <= '0;
            r_ls_sync1 <= '0;
        end else begin
            r_en_sync  <= {r_en_sync[0], directControlEn};
            r_ls_sync0 <= directControlLineState;
            r_ls_sync1 <= r_ls_sync0;
        end
    end

    assign w_en = r_en_sync[1];
    assign w_ls = r_ls_sync1;
`else
    assign w_en = directControlEn;
    assign w_ls = directControlLineState;
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_req;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_data;
    logic [CNTL_W-1:0]     r_cntl;
    logic                  r_busy;
    logic [LS_W-1:0]       r_last_ls;
    logic [REFRESH_W-1:0]  r_ref_cnt;

    state_t                w_state;
    logic                  w_req;
    logic                  w_wen;
    logic [DATA_W-1:0]     w_data;
    logic [CNTL_W-1:0]     w_cntl;
    logic                  w_busy;
    logic [LS_W-1:0]       w_last_ls;
    logic [REFRESH_W-1:0]  w_ref_cnt;
    logic [REFRESH_W-1:0]  w_ref_last;

    assign w_ref_last = refreshPeriod - c_ref_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_INIT;
            r_req     <= 1'b0;
            r_wen     <= 1'b0;
            r_data    <= '0;
            r_cntl    <= '0;
            r_busy    <= 1'b0;
            r_last_ls <= '0;
            r_ref_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_req     <= w_req;
            r_wen     <= w_wen;
            r_data    <= w_data;
            r_cntl    <= w_cntl;
            r_busy    <= w_busy;
            r_last_ls <= w_last_ls;
            r_ref_cnt <= w_ref_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_req     = r_req;
        w_wen     = 1'b0;
        w_data    = r_data;
        w_cntl    = r_cntl;
        w_last_ls = r_last_ls;
        w_ref_cnt = r_ref_cnt;

        case (r_state)
            S_INIT: begin
                w_req   = 1'b1;
                w_state = S_REQ_REL;
            end
            S_REQ_REL: begin
                if (SCTxPortGnt) begin
                    w_state = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (SCTxPortRdy) begin
                    w_wen   = 1'b1;
                    w_data  = '0;
                    w_cntl  = IDLE_CNTL;
                    w_state = S_REL_DONE;
                end
            end
            S_REL_DONE: begin
                w_req   = 1'b0;
                w_state = S_IDLE;
            end
            S_IDLE: begin
                if (w_en) begin
                    w_req   = 1'b1;
                    w_state = S_REQ_DIR;
                end
            end
            S_REQ_DIR: begin
                if (SCTxPortGnt) begin
                    w_state = S_WAIT_DIR;
                end
            end
            S_WAIT_DIR: begin
                // Line state is sampled on the Rdy cycle so that the most
                // recent value is written after an arbitrarily long wait.
                if (SCTxPortRdy) begin
                    w_wen     = 1'b1;
                    w_data    = DATA_W'(w_ls);
                    w_cntl    = DIRECT_CNTL;
                    w_last_ls = w_ls;
                    w_ref_cnt = '0;
                    w_state   = S_HOLD;
                end
            end
            S_HOLD: begin
                // The grant is kept while holding, so both exits go
                // straight to a WAIT state without re-arbitrating.
                if (!w_en) begin
                    w_state = S_WAIT_REL;
                end else if (w_ls != r_last_ls) begin
                    w_state = S_WAIT_DIR;
                end else if (!r_wen) begin
                    // The cycle carrying the write pulse is not a hold
                    // cycle, so a refresh period of N gives N quiet hold
                    // cycles, one wait cycle and one write cycle.
                    if ((refreshPeriod != '0) && (r_ref_cnt == w_ref_last)) begin
                        w_state = S_WAIT_DIR;
                    end else if (r_ref_cnt != '1) begin
                        w_ref_cnt = r_ref_cnt + c_ref_one;
                    end
                end
            end
            default: begin
                w_state = S_INIT;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign SCTxPortReq  = r_req;
    assign SCTxPortWEn  = r_wen;
    assign SCTxPortData = r_data;
    assign SCTxPortCntl = r_cntl;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_slave_direct_ctrl_gen.sv
// ============================================================================
// Module      : tb_slave_direct_ctrl_gen
// Description : Self-checking bench for slave_direct_ctrl_gen (default
//               build, no input synchroniser). Directed scenarios followed
//               by randomized traffic, all checked against a transaction
//               model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slave_direct_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  ls;
    logic [15:0] per;
    logic        gnt;
    logic        rdy;
    logic        req;
    logic        wen;
    logic [7:0]  data;
    logic [7:0]  cntl;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    slave_direct_ctrl_gen dut (
        .clk                    (clk),
        .rst                    (rst),
        .directControlEn        (en),
        .directControlLineState (ls),
        .refreshPeriod          (per),
        .SCTxPortGnt            (gnt),
        .SCTxPortRdy            (rdy),
        .SCTxPortReq            (req),
        .SCTxPortWEn            (wen),
        .SCTxPortData           (data),
        .SCTxPortCntl           (cntl),
        .busy                   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: tracks which write is owed to the port, whether
    // the port is owned, and how long the current line state has been held.
    // ------------------------------------------------------------------
    localparam int JOB_NONE = 0;
    localparam int JOB_REL  = 1;
    localparam int JOB_DIR  = 2;

    bit         m_init, m_closing, m_has_port, m_holding, m_fresh;
    int         m_job;
    int         m_cnt;
    logic [1:0] m_last;
    logic       m_req, m_wen, m_busy;
    logic [7:0] m_data, m_cntl;

    task automatic model_reset();
        m_init = 1; m_closing = 0; m_has_port = 0; m_holding = 0; m_fresh = 0;
        m_job = JOB_REL; m_cnt = 0; m_last = 2'b00;
        m_req = 0; m_wen = 0; m_busy = 0; m_data = 8'h00; m_cntl = 8'h00;
    endtask

    task automatic model_step();
        m_wen = 0;
        if (m_init) begin
            m_init = 0;
            m_req  = 1;
        end else if (m_closing) begin
            m_closing  = 0;
            m_req      = 0;
            m_has_port = 0;
        end else if (m_job != JOB_NONE) begin
            if (!m_has_port) begin
                m_has_port = gnt;
            end else if (rdy) begin
                m_wen = 1;
                if (m_job == JOB_REL) begin
                    m_data    = 8'h00;
                    m_cntl    = 8'h05;
                    m_closing = 1;
                end else begin
                    m_data    = {6'b0, ls};
                    m_cntl    = 8'h00;
                    m_last    = ls;
                    m_holding = 1;
                    m_fresh   = 1;
                    m_cnt     = 0;
                end
                m_job = JOB_NONE;
            end
        end else if (m_holding) begin
            if (!en) begin
                m_holding = 0; m_job = JOB_REL;
            end else if (ls != m_last) begin
                m_holding = 0; m_job = JOB_DIR;
            end else if (m_fresh) begin
                m_fresh = 0;
            end else if (per != 0 && m_cnt == int'(per) - 1) begin
                m_holding = 0; m_job = JOB_DIR;
            end else if (m_cnt < 65535) begin
                m_cnt++;
            end
        end else if (en) begin
            m_req = 1;
            m_job = JOB_DIR;
        end
        m_busy = m_req || m_closing || m_holding || (m_job != JOB_NONE);
    endtask

    // ------------------------------------------------------------------
    // One clock: model advances on the edge, outputs compared mid-cycle,
    // inputs (set by the caller before the call) stay stable across the edge.
    // ------------------------------------------------------------------
    int   cyc = 0;
    logic prev_wen = 1'b0;
    int   wen_times[$];

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("req",  {31'b0, req},  {31'b0, m_req});
        check("wen",  {31'b0, wen},  {31'b0, m_wen});
        check("data", {24'b0, data}, {24'b0, m_data});
        check("cntl", {24'b0, cntl}, {24'b0, m_cntl});
        check("busy", {31'b0, busy}, {31'b0, m_busy});
        check("wen_back_to_back", {31'b0, wen & prev_wen}, 32'd0);
        prev_wen = wen;
        if (wen) wen_times.push_back(cyc);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},  {31'b0, req},  32'd0);
        check({tag, "_wen"},  {31'b0, wen},  32'd0);
        check({tag, "_data"}, {24'b0, data}, 32'd0);
        check({tag, "_cntl"}, {24'b0, cntl}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int n_before;
    int start_idx;

    initial begin
        rst = 1'b1; en = 1'b0; ls = 2'b00; per = 16'd0; gnt = 1'b1; rdy = 1'b1;
        model_reset();
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Post-reset release write, then idle.
        run(6);
        check("release_pulses", wen_times.size(), 32'd1);

        // Direct write of LS=2, then silence with refresh disabled.
        en = 1'b1; ls = 2'b10;
        n_before = wen_times.size();
        run(12);
        check("direct_pulses", wen_times.size() - n_before, 32'd1);

        // Line-state change while holding: WEn two cycles after it is seen.
        ls = 2'b01;
        n_before = wen_times.size();
        run(6);
        check("ls_change_pulses", wen_times.size() - n_before, 32'd1);
        if (wen_times.size() > n_before)
            check("ls_change_latency", wen_times[n_before] - (cyc - 6), 32'd2);

        // Refresh period 4: one write every 6 cycles.
        ls = 2'b10; per = 16'd4;
        start_idx = wen_times.size();
        run(30);
        check("refresh_enough", {31'b0, (wen_times.size() - start_idx) >= 4}, 32'd1);
        for (int i = start_idx + 1; i < wen_times.size(); i++)
            check("refresh_spacing", wen_times[i] - wen_times[i-1], 32'd6);

        // Drop enable while holding: release without dropping Req first.
        per = 16'd0; en = 1'b0;
        run(6);

        // Stall in the direct wait, then assert reset asynchronously.
        en = 1'b1; rdy = 1'b0;
        run(5);
        check("stall_req", {31'b0, req}, 32'd1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; en = 1'b0;
        prev_wen = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0)  ls = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) per = 16'($urandom_range(0, 6));
            gnt = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
